vram1_access_ctrl: RTL and testbench
====================================

Name: vram1_access_ctrl

Overview:
Initiator-side controller for one TC5533P-style VRAM bank (a 4k x 8 synchronous SRAM model with active-low i_WR_n/i_RD_n and a registered o_DOUT). It arbitrates between a CPU port (level-held request/ack) and a video fetch port (single-cycle request pulse). It generates the SRAM address, data and strobes, and returns read data to whichever side issued the read. Video has priority, and a bounded starvation counter guarantees CPU progress.

Parameters:
AW, 12, address width (SRAM depth 2^AW)
DW, 8, data width
CPU_MAX_WAIT, 4, number of lost arbitration rounds after which a waiting CPU request beats a pending video request

Ports:
i_MCLK  in  1  master clock, all logic on posedge
i_RST_n  in  1  reset, asynchronous, active-low
i_CPU_REQ  in  1  CPU request, level, held until o_CPU_ACK
i_CPU_RW  in  1  1=read, 0=write; stable while i_CPU_REQ high
i_CPU_ADDR  in  AW  CPU address
i_CPU_DIN  in  DW  CPU write data
o_CPU_DOUT  out  DW  CPU read data, valid in the o_CPU_ACK cycle of a read, held until the next CPU read
o_CPU_ACK  out  1  one-cycle completion pulse
i_VID_REQ  in  1  video read request, one-cycle pulse
i_VID_ADDR  in  AW  video address, sampled with i_VID_REQ
o_VID_DOUT  out  DW  video read data, held until the next video read
o_VID_VALID  out  1  one-cycle pulse, o_VID_DOUT valid
o_VID_OVF  out  1  sticky: a video request was dropped
o_RAM_ADDR  out  AW  to SRAM i_ADDR
o_RAM_DIN  out  DW  to SRAM i_DIN
o_RAM_WR_n  out  1  to SRAM i_WR_n
o_RAM_RD_n  out  1  to SRAM i_RD_n
i_RAM_DOUT  in  DW  from SRAM o_DOUT

Behaviour:
- Reset (asynchronous assert; release is synchronous to i_MCLK):
  - state IDLE; o_RAM_WR_n=1, o_RAM_RD_n=1; o_RAM_ADDR=0, o_RAM_DIN=0.
  - o_CPU_DOUT=0, o_VID_DOUT=0; o_CPU_ACK=0, o_VID_VALID=0, o_VID_OVF=0.
  - Video pending register and wait counter cleared.
  - Reset mid-transaction aborts it; no ACK or VALID is issued for the aborted access.
- All outputs are registered.
- Video capture: i_VID_REQ high captures i_VID_ADDR into a 1-deep pending slot in any state.
  - Request while the slot is full and not being granted in that cycle: the new request is dropped, the old one is kept, and o_VID_OVF is set.
  - Request in the same cycle the slot is granted: the slot reloads with the new address, no overflow.
- States: IDLE, VRD, VLAT, CRD, CLAT, CWR, CACK.
- IDLE arbitration, evaluated every IDLE cycle. Candidates are the pending slot, or i_VID_REQ directly (bypass) when the slot is empty.
  - Video candidate present and wait counter < CPU_MAX_WAIT: grant video -> VRD. If i_CPU_REQ is high, increment the wait counter (saturating).
  - Otherwise i_CPU_REQ high: grant CPU -> CRD if i_CPU_RW=1, else CWR. Clear the wait counter.
- VRD: o_RAM_RD_n=0, o_RAM_ADDR=video address; -> VLAT.
- VLAT: strobes high; -> IDLE. On this edge i_RAM_DOUT is captured into o_VID_DOUT, with o_VID_VALID=1 for the next cycle.
- CRD: o_RAM_RD_n=0, o_RAM_ADDR=i_CPU_ADDR; -> CLAT.
- CLAT: -> CACK. On this edge i_RAM_DOUT is captured into o_CPU_DOUT.
- CWR: o_RAM_WR_n=0, o_RAM_ADDR=i_CPU_ADDR, o_RAM_DIN=i_CPU_DIN; -> CACK.
- CACK: o_CPU_ACK=1; -> IDLE. i_CPU_REQ is not sampled in CACK, so an unbroken REQ starts a new transaction only from IDLE.
- Latency, with the request seen in IDLE in cycle k:
  - video/CPU read: RD_n low in k+1; VALID/ACK with data in k+3.
  - CPU write: WR_n low in k+1; ACK in k+2.
  - Back-to-back video throughput: one read per 3 cycles.
- Invariants:
  - o_RAM_WR_n and o_RAM_RD_n are never low simultaneously.
  - Each strobe is low for exactly one cycle per access.
  - The CPU address is latched at grant; changes to i_CPU_ADDR mid-transaction are ignored.

Test Plan:
1. Reset then CPU write: REQ=1, RW=0, ADDR=0x123, DIN=0xA5 in IDLE cycle k -> WR_n=0 with ADDR=0x123, DIN=0xA5 in k+1; ACK pulse in k+2; SRAM[0x123]=0xA5.
2. CPU read of 0x123 after test 1 -> RD_n=0 in k+1; ACK in k+3 with o_CPU_DOUT=0xA5.
3. Video read: preload SRAM[0x7FF]=0x3C; VID_REQ pulse with ADDR=0x7FF in k -> RD_n=0 in k+1; VALID in k+3 with o_VID_DOUT=0x3C; o_VID_OVF stays 0.
4. Arbitration/starvation (CPU_MAX_WAIT=4): CPU read held high while VID_REQ pulses every 3 cycles -> exactly 4 video grants, then the CPU is granted; the wait counter returns to 0; strobes never overlap.
5. Overflow: three VID_REQ pulses on consecutive cycles from IDLE -> first granted via bypass, second held pending, third dropped; o_VID_OVF=1 and stays 1; exactly two VALID pulses with the first two addresses' data.
6. Reset mid-op: assert i_RST_n=0 in the CLAT cycle -> all outputs return to reset values immediately, no ACK; after release a fresh CPU write completes normally.

Source files
------------

// File: rtl/vram1_access_ctrl.sv
// Access controller for one VRAM bank. It arbitrates a level-held CPU port against
// pulsed video fetches, and video has priority subject to a CPU starvation bound.
module vram1_access_ctrl #(
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic          i_MCLK,
  input  logic          i_RST_n,
  input  logic          i_CPU_REQ,
  input  logic          i_CPU_RW,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [DW-1:0] i_CPU_DIN,
  output logic [DW-1:0] o_CPU_DOUT,
  output logic          o_CPU_ACK,
  input  logic          i_VID_REQ,
  input  logic [AW-1:0] i_VID_ADDR,
  output logic [DW-1:0] o_VID_DOUT,
  output logic          o_VID_VALID,
  output logic          o_VID_OVF,
  output logic [AW-1:0] o_RAM_ADDR,
  output logic [DW-1:0] o_RAM_DIN,
  output logic          o_RAM_WR_n,
  output logic          o_RAM_RD_n,
  input  logic [DW-1:0] i_RAM_DOUT
);

  localparam int WCW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(CPU_MAX_WAIT);

  typedef enum logic [2:0] {IDLE, VRD, VLAT, CRD, CLAT, CWR, CACK} state_t;

  state_t          state, state_nxt;
  logic            vid_pend;
  logic [AW-1:0]   vid_pend_addr;
  logic [WCW-1:0]  wait_cnt;
  logic            vid_cand;
  logic [AW-1:0]   vid_cand_addr;
  logic            grant_vid;
  logic            grant_cpu;

  always_comb begin
    vid_cand      = vid_pend | i_VID_REQ;
    vid_cand_addr = vid_pend ? vid_pend_addr : i_VID_ADDR;
    grant_vid     = 1'b0;
    grant_cpu     = 1'b0;
    state_nxt     = state;
    case (state)
      IDLE: begin
        // With no CPU waiting, video is never held back by a saturated counter.
        if (vid_cand && ((wait_cnt < WAIT_MAX) || !i_CPU_REQ)) begin
          grant_vid = 1'b1;
          state_nxt = VRD;
        end else if (i_CPU_REQ) begin
          grant_cpu = 1'b1;
          state_nxt = i_CPU_RW ? CRD : CWR;
        end
      end
      VRD:     state_nxt = VLAT;
      VLAT:    state_nxt = IDLE;
      CRD:     state_nxt = CLAT;
      CLAT:    state_nxt = CACK;
      CWR:     state_nxt = CACK;
      CACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state         <= IDLE;
      vid_pend      <= 1'b0;
      vid_pend_addr <= '0;
      wait_cnt      <= '0;
      o_VID_OVF     <= 1'b0;
      o_CPU_ACK     <= 1'b0;
      o_VID_VALID   <= 1'b0;
      o_RAM_RD_n    <= 1'b1;
      o_RAM_WR_n    <= 1'b1;
    end else begin
      state <= state_nxt;

      // A granted slot may reload in the same cycle; otherwise a second request is lost.
      if (grant_vid && vid_pend) begin
        vid_pend <= i_VID_REQ;
        if (i_VID_REQ)
          vid_pend_addr <= i_VID_ADDR;
      end else if (i_VID_REQ && !grant_vid) begin
        if (vid_pend) begin
          o_VID_OVF <= 1'b1;
        end else begin
          vid_pend      <= 1'b1;
          vid_pend_addr <= i_VID_ADDR;
        end
      end

      if (grant_vid && i_CPU_REQ && (wait_cnt < WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
      else if (grant_cpu)
        wait_cnt <= '0;

      o_RAM_RD_n  <= !(grant_vid || (grant_cpu && i_CPU_RW));
      o_RAM_WR_n  <= !(grant_cpu && !i_CPU_RW);
      o_VID_VALID <= (state == VLAT);
      o_CPU_ACK   <= (state_nxt == CACK);
    end
  end

  // Datapath: address/data latched at grant, read data captured one cycle after the strobe.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      o_RAM_ADDR <= '0;
      o_RAM_DIN  <= '0;
      o_CPU_DOUT <= '0;
      o_VID_DOUT <= '0;
    end else begin
      if (grant_vid) begin
        o_RAM_ADDR <= vid_cand_addr;
      end else if (grant_cpu) begin
        o_RAM_ADDR <= i_CPU_ADDR;
        if (!i_CPU_RW)
          o_RAM_DIN <= i_CPU_DIN;
      end
      if (state == VLAT)
        o_VID_DOUT <= i_RAM_DOUT;
      if (state == CLAT)
        o_CPU_DOUT <= i_RAM_DOUT;
    end
  end

endmodule

// File: tb/tb_vram1_access_ctrl.sv
// Directed bench for vram1_access_ctrl with a behavioural 4k x 8 registered-output SRAM.
module tb_vram1_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_rw = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        vid_req = 1'b0;
  logic [11:0] vid_addr = '0;
  logic [7:0]  vid_dout;
  logic        vid_valid, vid_ovf;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_wr_n, ram_rd_n;
  logic [7:0]  ram_dout = '0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  vid_log [0:63];
  int          vid_cnt = 0, ack_cnt = 0, overlap = 0, long_strobe = 0;
  logic        rd_prev_low = 1'b0, wr_prev_low = 1'b0;
  int          checks = 0, errors = 0;
  int          base_v, base_a;
  logic        got;

  always #5 clk = ~clk;

  vram1_access_ctrl #(.AW(12), .DW(8), .CPU_MAX_WAIT(4)) dut (
    .i_MCLK(clk), .i_RST_n(rst_n),
    .i_CPU_REQ(cpu_req), .i_CPU_RW(cpu_rw), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
    .o_CPU_DOUT(cpu_dout), .o_CPU_ACK(cpu_ack),
    .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr),
    .o_VID_DOUT(vid_dout), .o_VID_VALID(vid_valid), .o_VID_OVF(vid_ovf),
    .o_RAM_ADDR(ram_addr), .o_RAM_DIN(ram_din), .o_RAM_WR_n(ram_wr_n), .o_RAM_RD_n(ram_rd_n),
    .i_RAM_DOUT(ram_dout)
  );

  always @(posedge clk) begin
    if (!ram_wr_n) mem[ram_addr] <= ram_din;
    if (!ram_rd_n) ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (vid_valid) begin
        vid_log[vid_cnt[5:0]] <= vid_dout;
        vid_cnt <= vid_cnt + 1;
      end
      if (cpu_ack) ack_cnt <= ack_cnt + 1;
      if (!ram_wr_n && !ram_rd_n) overlap <= overlap + 1;
      if ((!ram_rd_n && rd_prev_low) || (!ram_wr_n && wr_prev_low)) long_strobe <= long_strobe + 1;
      rd_prev_low <= !ram_rd_n;
      wr_prev_low <= !ram_wr_n;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    logic seen;
    seen = 1'b0;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_din = d;
    for (int i = 0; i < 10 && !seen; i++) begin
      step;
      if (cpu_ack) seen = 1'b1;
    end
    cpu_req = 1'b0;
    check("preload_ack", 32'(seen), 1);
    step;
  endtask

  initial begin
    repeat (3) step;
    rst_n = 1'b1;
    step;
    check("rst_strobes", 32'({ram_wr_n, ram_rd_n}), 32'h3);
    check("rst_ram_addr_din", 32'({ram_addr, ram_din}), 0);
    check("rst_pulses", 32'({cpu_ack, vid_valid, vid_ovf}), 0);
    check("rst_douts", 32'({cpu_dout, vid_dout}), 0);

    // Test 1: CPU write 0x123 <- 0xA5
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h123; cpu_din = 8'hA5;
    step;
    check("t1_wr_low", 32'({ram_wr_n, ram_rd_n}), 32'h1);
    check("t1_addr", 32'(ram_addr), 32'h123);
    check("t1_din", 32'(ram_din), 32'hA5);
    step;
    check("t1_ack", 32'({cpu_ack, ram_wr_n}), 32'h3);
    cpu_req = 1'b0;
    check("t1_mem", 32'(mem[12'h123]), 32'hA5);
    step;
    check("t1_ack_pulse", 32'(cpu_ack), 0);

    // Test 2: CPU read 0x123; the address changes mid-transaction and must be ignored
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h123;
    step;
    check("t2_rd_low", 32'({ram_wr_n, ram_rd_n}), 32'h2);
    check("t2_addr", 32'(ram_addr), 32'h123);
    cpu_addr = 12'h456;
    step;
    check("t2_no_early_ack", 32'({cpu_ack, ram_rd_n}), 32'h1);
    step;
    check("t2_ack", 32'(cpu_ack), 1);
    check("t2_dout", 32'(cpu_dout), 32'hA5);
    cpu_req = 1'b0;
    step;

    // Test 3: video read of 0x7FF
    cpu_write(12'h7FF, 8'h3C);
    vid_req = 1'b1; vid_addr = 12'h7FF;
    step;
    vid_req = 1'b0;
    check("t3_rd_low", 32'({ram_wr_n, ram_rd_n}), 32'h2);
    check("t3_addr", 32'(ram_addr), 32'h7FF);
    step;
    check("t3_no_early_valid", 32'({vid_valid, ram_rd_n}), 32'h1);
    step;
    check("t3_valid", 32'(vid_valid), 1);
    check("t3_dout", 32'(vid_dout), 32'h3C);
    check("t3_ovf", 32'(vid_ovf), 0);
    step;
    check("t3_valid_pulse", 32'(vid_valid), 0);

    // Test 4: starvation bound; CPU read held while video pulses every 3 cycles
    for (int i = 0; i < 5; i++) cpu_write(12'h010 + 12'(i), 8'h80 + 8'(i));
    base_v = vid_cnt;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h123;
    vid_req = 1'b1; vid_addr = 12'h010;
    for (int i = 1; i <= 4; i++) begin
      step; vid_req = 1'b0;
      step; step;
      vid_req = 1'b1; vid_addr = 12'h010 + 12'(i);
    end
    step;
    vid_req = 1'b0;
    check("t4_cpu_granted_rd", 32'(ram_rd_n), 0);
    check("t4_cpu_granted_addr", 32'(ram_addr), 32'h123);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      if (cpu_ack) got = 1'b1;
    end
    cpu_req = 1'b0;
    check("t4_ack_seen", 32'(got), 1);
    check("t4_vid_before_cpu", 32'(vid_cnt - base_v), 4);
    check("t4_cpu_dout", 32'(cpu_dout), 32'hA5);
    check("t4_wait_cnt_clr", 32'(dut.wait_cnt), 0);
    repeat (6) step;
    check("t4_fifth_vid", 32'(vid_cnt - base_v), 5);
    for (int i = 0; i < 5; i++)
      check("t4_vid_data", 32'(vid_log[base_v + i]), 32'h80 + 32'(i));
    check("t4_ovf", 32'(vid_ovf), 0);

    // Test 5: three back-to-back video pulses; third is dropped
    cpu_write(12'h020, 8'h11);
    cpu_write(12'h021, 8'h22);
    cpu_write(12'h022, 8'h33);
    base_v = vid_cnt;
    vid_req = 1'b1; vid_addr = 12'h020;
    step; vid_addr = 12'h021;
    step; vid_addr = 12'h022;
    step; vid_req = 1'b0;
    check("t5_ovf_set", 32'(vid_ovf), 1);
    repeat (8) step;
    check("t5_valid_count", 32'(vid_cnt - base_v), 2);
    check("t5_data0", 32'(vid_log[base_v]), 32'h11);
    check("t5_data1", 32'(vid_log[base_v + 1]), 32'h22);
    check("t5_ovf_sticky", 32'(vid_ovf), 1);

    // Test 6: reset during CLAT
    base_a = ack_cnt;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h7FF;
    step; step;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("t6_strobes", 32'({ram_wr_n, ram_rd_n}), 32'h3);
    check("t6_ram_addr_din", 32'({ram_addr, ram_din}), 0);
    check("t6_pulses_ovf", 32'({cpu_ack, vid_valid, vid_ovf}), 0);
    check("t6_douts", 32'({cpu_dout, vid_dout}), 0);
    step; step;
    rst_n = 1'b1;
    repeat (3) step;
    check("t6_no_ack", 32'(ack_cnt - base_a), 0);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h055; cpu_din = 8'h5A;
    step;
    check("t6_wr_low", 32'({ram_wr_n, ram_rd_n}), 32'h1);
    check("t6_wr_addr_din", 32'({ram_addr, ram_din}), 32'h0555A);
    step;
    check("t6_ack", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    check("t6_mem", 32'(mem[12'h055]), 32'h5A);
    step;

    check("strobe_overlap", 32'(overlap), 0);
    check("strobe_single_cycle", 32'(long_strobe), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
